// File: rtl/t05_sram_arb_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// t05_sram_arb_pkg: shared types, client ids and helpers for the SRAM arbiter
// Revision: 1.0
// -----------------------------------------------------------------------------
package t05_sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4
  } arb_state_e;

  localparam int MAXW = 4;

  localparam int CL_HIST  = 0;
  localparam int CL_FLV   = 1;
  localparam int CL_HTREE = 2;
  localparam int CL_CB    = 3;
  localparam int CL_TRANS = 4;

  localparam logic [31:0] HIST_BASE  = 32'h3300_0000;
  localparam logic [31:0] HTREE_BASE = 32'h3300_2000;
  localparam logic [31:0] CB_BASE    = 32'h3300_3000;

  // Index of the final word: zero length means one word, overlong is clamped.
  function automatic logic [1:0] last_word(input logic [2:0] len);
    if (len == 3'd0) return 2'd0;
    else if (int'(len) > MAXW) return 2'(MAXW - 1);
    else return 2'(len - 3'd1);
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] k);
    case (k)
      2'd0:    return v[127:96];
      2'd1:    return v[95:64];
      2'd2:    return v[63:32];
      default: return v[31:0];
    endcase
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] k,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = v;
    case (k)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/t05_rr_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// t05_rr_arbiter: combinational round-robin pick starting at ptr, wrapping
// Revision: 1.0
// -----------------------------------------------------------------------------
module t05_rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        valid            = 1'b1;
        gnt_onehot[cand] = 1'b1;
        gnt_idx          = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/t05_sram_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// t05_sram_arbiter: round-robin burst sharing of the Wishbone SRAM master port
// Revision: 1.0
// -----------------------------------------------------------------------------
module t05_sram_arbiter
  import t05_sram_arb_pkg::*;
#(
  parameter int NREQ = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*32-1:0]    req_addr,
  input  logic [NREQ*3-1:0]     req_len,
  input  logic [NREQ*128-1:0]   req_wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [127:0]          rdata,
  output logic                  wr_en,
  output logic                  r_en,
  output logic [3:0]            select,
  output logic [31:0]           addr,
  output logic [31:0]           data_i,
  input  logic [31:0]           data_o,
  input  logic                  busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            we_q, we_d;
  logic [31:0]     base_q, base_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      k_q, k_d;
  logic [127:0]    wdata_q, wdata_d;
  logic [127:0]    rdata_q, rdata_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_i_q, data_i_d;

  logic [NREQ-1:0] arb_onehot;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;

  logic            sel_we;
  logic [31:0]     sel_addr;
  logic [2:0]      sel_len;
  logic [127:0]    sel_wdata;
  logic [1:0]      k_nxt;

  t05_rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .valid      (arb_valid)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_onehot[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[32*i +: 32];
        sel_len   = req_len[3*i +: 3];
        sel_wdata = req_wdata[128*i +: 128];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    we_d     = we_q;
    base_d   = base_q;
    last_d   = last_q;
    k_d      = k_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    data_i_d = data_i_q;
    k_nxt    = k_q + 2'd1;

    unique case (state_q)
      IDLE: begin
        // A busy bus blocks the grant so no strobe can overlap a foreign cycle.
        if (arb_valid && !busy_o) begin
          gnt_d    = arb_onehot;
          owner_d  = arb_idx;
          we_d     = sel_we;
          base_d   = {sel_addr[31:2], 2'b00};
          last_d   = last_word(sel_len);
          k_d      = 2'd0;
          wdata_d  = sel_wdata;
          addr_d   = {sel_addr[31:2], 2'b00};
          data_i_d = sel_we ? get_word(sel_wdata, 2'd0) : 32'd0;
          if (!sel_we) rdata_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy_o) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!busy_o) begin
          if (!we_q) rdata_d = put_word(rdata_q, k_q, data_o);
          if (k_q == last_q) begin
            state_d = FINISH;
          end else begin
            k_d      = k_nxt;
            addr_d   = base_q + {28'd0, k_nxt, 2'b00};
            data_i_d = we_q ? get_word(wdata_q, k_nxt) : 32'd0;
            state_d  = ISSUE;
          end
        end
      end
      FINISH: begin
        if (owner_q == IW'(NREQ - 1)) ptr_d = '0;
        else ptr_d = owner_q + 1'b1;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      we_q     <= 1'b0;
      base_q   <= '0;
      last_q   <= '0;
      k_q      <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      data_i_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      base_q   <= base_d;
      last_q   <= last_d;
      k_q      <= k_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      data_i_q <= data_i_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = (state_q == FINISH) ? gnt_q : '0;
  assign rdata  = rdata_q;
  assign wr_en  = (state_q == ISSUE) && we_q;
  assign r_en   = (state_q == ISSUE) && !we_q;
  assign select = (state_q == ISSUE) ? 4'b1111 : 4'b0000;
  assign addr   = addr_q;
  assign data_i = data_i_q;

endmodule
`default_nettype wire

// File: tb/tb_t05_sram_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_t05_sram_arbiter: directed bench with a simple busy-handshake bus model
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_t05_sram_arbiter;
  import t05_sram_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   req = '0;
  logic [4:0]   req_we = '0;
  logic [159:0] req_addr = '0;
  logic [14:0]  req_len = '0;
  logic [639:0] req_wdata = '0;
  logic [4:0]   gnt, done;
  logic [127:0] rdata;
  logic         wr_en, r_en;
  logic [3:0]   select;
  logic [31:0]  addr, data_i;
  logic [31:0]  data_o = '0;
  logic         busy_o;

  logic         busy_force = 1'b0;
  int           busy_len = 1;
  int           busy_cnt = 0;
  logic [31:0]  rd_vals [0:7];
  int           rd_idx = 0;
  int           rd_off = 0;

  int           cyc = 0;
  int           wr_cnt = 0, rd_cnt = 0, done_cnt = 0, sel_bad = 0, strobe_busy = 0;
  logic [31:0]  addr_log [$];
  logic [31:0]  data_log [$];
  int           strobe_cyc [$];
  int           gnt_log [$];
  logic [4:0]   gnt_prev = '0;

  int errors = 0;
  int checks = 0;

  t05_sram_arbiter #(.NREQ(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .wr_en     (wr_en),
    .r_en      (r_en),
    .select    (select),
    .addr      (addr),
    .data_i    (data_i),
    .data_o    (data_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  assign busy_o = busy_force | (busy_cnt != 0);

  // Bus: every strobe raises busy for busy_len cycles and returns the next read word.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en || r_en) begin
      busy_cnt <= busy_len;
      if (r_en) begin
        data_o <= rd_vals[3'(rd_idx - rd_off)];
        rd_idx <= rd_idx + 1;
      end
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  function automatic int onehot_idx(input logic [4:0] g);
    int r = -1;
    int n = 0;
    for (int i = 0; i < 5; i++) if (g[i]) begin r = i; n++; end
    return (n == 1) ? r : 99;
  endfunction

  always @(negedge clk) begin
    if (wr_en || r_en) begin
      addr_log.push_back(addr);
      data_log.push_back(data_i);
      strobe_cyc.push_back(cyc);
      if (wr_en) wr_cnt <= wr_cnt + 1;
      if (r_en) rd_cnt <= rd_cnt + 1;
      if (select !== 4'hF) sel_bad <= sel_bad + 1;
      if (busy_o) strobe_busy <= strobe_busy + 1;
    end else if (select !== 4'h0) begin
      sel_bad <= sel_bad + 1;
    end
    if (done != 5'b0) done_cnt <= done_cnt + 1;
    if (gnt_prev == 5'b0 && gnt != 5'b0) gnt_log.push_back(onehot_idx(gnt));
    gnt_prev <= gnt;
  end

  task automatic set_client(input int i, input logic we, input logic [31:0] a,
                            input logic [2:0] len, input logic [127:0] wd);
    req_we[i]               = we;
    req_addr[32*i +: 32]    = a;
    req_len[3*i +: 3]       = len;
    req_wdata[128*i +: 128] = wd;
  endtask

  task automatic wait_done(input int maxc, output int ncyc, output logic [4:0] dval);
    ncyc = -1;
    dval = '0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (done != 5'b0) begin
        ncyc = c + 1;
        dval = done;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    if (gnt !== 5'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++;
    if (done !== 5'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (rdata !== 128'b0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++;
    if ({wr_en, r_en, select} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0", {wr_en, r_en, select});
    end
    checks++;
    if (addr !== 32'b0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
    checks++;
    if (data_i !== 32'b0) begin errors++; $display("FAIL reset_data_i: got %h want 0", data_i); end
    checks++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin;
    int g0;
    int exp_rr [6] = '{0, 1, 2, 3, 4, 0};
    for (int i = 0; i < 5; i++) set_client(i, 1'b0, 32'h3300_0000 + 32'(i * 256), 3'd1, '0);
    g0 = gnt_log.size();
    req = 5'b11111;
    for (int c = 0; c < 80 && gnt_log.size() < g0 + 6; c++) begin
      @(negedge clk);
      #1;
    end
    req = 5'b0;
    if (gnt_log.size() < g0 + 6) begin
      errors++; $display("FAIL rr_timeout: got %0d grants want 6", gnt_log.size() - g0);
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (gnt_log[g0 + k] != exp_rr[k]) begin
          errors++; $display("FAIL rr_order[%0d]: got client %0d want %0d", k, gnt_log[g0 + k], exp_rr[k]);
        end
        checks++;
      end
    end
    checks++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_read;
    int a0, d0, dcyc;
    logic [4:0] dval;
    logic [127:0] rdv;
    rd_off = rd_idx;
    rd_vals[0] = 32'hAAAA_0001;
    rd_vals[1] = 32'hAAAA_0002;
    set_client(1, 1'b0, 32'h3300_1000, 3'd2, '0);
    a0 = addr_log.size();
    d0 = done_cnt;
    dcyc = -1; dval = '0; rdv = '0;
    req = 5'b00010;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 3) req[1] = 1'b0;
      if (done != 5'b0) begin dcyc = c + 1; dval = done; rdv = rdata; break; end
    end
    if (dcyc != 8) begin errors++; $display("FAIL rd_done_cycle: got %0d want 8", dcyc); end
    checks++;
    if (dval !== 5'b00010) begin errors++; $display("FAIL rd_done_owner: got %b want 00010", dval); end
    checks++;
    if (rdv !== {32'hAAAA_0001, 32'hAAAA_0002, 64'h0}) begin
      errors++; $display("FAIL rd_rdata: got %h want aaaa0001aaaa0002 then zeros", rdv);
    end
    checks++;
    @(negedge clk);
    if (done !== 5'b0) begin errors++; $display("FAIL rd_done_pulse: got %b want 0", done); end
    checks++;
    if (rdata !== {32'hAAAA_0001, 32'hAAAA_0002, 64'h0}) begin
      errors++; $display("FAIL rd_rdata_hold: got %h", rdata);
    end
    checks++;
    repeat (3) @(negedge clk);
    if (addr_log.size() - a0 != 2) begin
      errors++; $display("FAIL rd_strobes: got %0d want 2", addr_log.size() - a0);
    end
    checks++;
    if (addr_log[a0] !== 32'h3300_1000 || addr_log[a0 + 1] !== 32'h3300_1004) begin
      errors++; $display("FAIL rd_addr: got %h %h want 33001000 33001004", addr_log[a0], addr_log[a0 + 1]);
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL rd_done_count: got %0d want 1", done_cnt - d0); end
    checks++;
  endtask

  task automatic test_write_burst;
    int a0, d0, w0;
    logic [4:0] dval;
    logic [31:0] exp_w [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    set_client(3, 1'b1, 32'h3300_3072, 3'd4, 128'h11111111_22222222_33333333_44444444);
    a0 = addr_log.size(); d0 = done_cnt; w0 = wr_cnt;
    dval = '0;
    req = 5'b01000;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 2) set_client(3, 1'b1, 32'hDEAD_BEE0, 3'd1, {4{32'hFFFF_FFFF}});
      if (done != 5'b0) begin dval = done; break; end
    end
    req = 5'b0;
    repeat (4) @(negedge clk);
    if (dval !== 5'b01000) begin errors++; $display("FAIL wr_done_owner: got %b want 01000", dval); end
    checks++;
    if (wr_cnt - w0 != 4) begin errors++; $display("FAIL wr_strobe_cycles: got %0d want 4", wr_cnt - w0); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL wr_done_count: got %0d want 1", done_cnt - d0); end
    checks++;
    for (int k = 0; k < 4; k++) begin
      if (addr_log[a0 + k] !== 32'h3300_3070 + 32'(4 * k)) begin
        errors++; $display("FAIL wr_addr[%0d]: got %h want %h", k, addr_log[a0 + k], 32'h3300_3070 + 32'(4 * k));
      end
      checks++;
      if (data_log[a0 + k] !== exp_w[k]) begin
        errors++; $display("FAIL wr_data[%0d]: got %h want %h", k, data_log[a0 + k], exp_w[k]);
      end
      checks++;
    end
  endtask

  task automatic test_len_edges;
    int a0, w0, n;
    logic [4:0] dval;
    set_client(CL_HIST, 1'b1, HIST_BASE, 3'd0, {4{32'hCAFE_0000}});
    w0 = wr_cnt;
    req = 5'b00001;
    wait_done(40, n, dval);
    req = 5'b0;
    repeat (3) @(negedge clk);
    if (wr_cnt - w0 != 1) begin errors++; $display("FAIL len0_strobes: got %0d want 1", wr_cnt - w0); end
    checks++;

    set_client(CL_HIST, 1'b1, HIST_BASE + 32'h40, 3'd7, {4{32'hBEEF_0000}});
    w0 = wr_cnt; a0 = addr_log.size();
    req = 5'b00001;
    wait_done(60, n, dval);
    req = 5'b0;
    repeat (3) @(negedge clk);
    if (wr_cnt - w0 != 4) begin errors++; $display("FAIL len7_strobes: got %0d want 4", wr_cnt - w0); end
    checks++;
    if (addr_log[a0 + 3] !== 32'h3300_004C) begin
      errors++; $display("FAIL len7_last_addr: got %h want 3300004c", addr_log[a0 + 3]);
    end
    checks++;

    rd_off = rd_idx;
    rd_vals[0] = 32'h5555_AAAA;
    rd_vals[1] = 32'h6666_BBBB;
    set_client(CL_TRANS, 1'b0, 32'h3300_4000, 3'd1, '0);
    req = 5'b10000;
    wait_done(40, n, dval);
    req = 5'b0;
    repeat (3) @(negedge clk);
    if (dval !== 5'b10000) begin errors++; $display("FAIL len1_done: got %b want 10000", dval); end
    checks++;
    if (rdata !== {32'h5555_AAAA, 96'h0}) begin
      errors++; $display("FAIL len1_rdata: got %h want 5555aaaa then zeros", rdata);
    end
    checks++;
  endtask

  task automatic test_slow_bus;
    int a0, sb0, n;
    logic [4:0] dval;
    busy_len = 10;
    rd_off = rd_idx;
    rd_vals[0] = 32'h1234_5678;
    rd_vals[1] = 32'h9ABC_DEF0;
    set_client(CL_HTREE, 1'b0, 32'hFFFF_FFFC, 3'd2, '0);
    a0 = addr_log.size(); sb0 = strobe_busy;
    req = 5'b00100;
    wait_done(100, n, dval);
    req = 5'b0;
    repeat (3) @(negedge clk);
    busy_len = 1;
    if (dval !== 5'b00100) begin errors++; $display("FAIL slow_done: got %b want 00100", dval); end
    checks++;
    if (addr_log[a0] !== 32'hFFFF_FFFC || addr_log[a0 + 1] !== 32'h0) begin
      errors++; $display("FAIL slow_addr_wrap: got %h %h want fffffffc 00000000", addr_log[a0], addr_log[a0 + 1]);
    end
    checks++;
    if (strobe_cyc[a0 + 1] - strobe_cyc[a0] != 12) begin
      errors++; $display("FAIL slow_strobe_gap: got %0d want 12", strobe_cyc[a0 + 1] - strobe_cyc[a0]);
    end
    checks++;
    if (strobe_busy - sb0 != 0) begin
      errors++; $display("FAIL slow_strobe_while_busy: got %0d want 0", strobe_busy - sb0);
    end
    checks++;
    if (rdata !== {32'h1234_5678, 32'h9ABC_DEF0, 64'h0}) begin
      errors++; $display("FAIL slow_rdata: got %h", rdata);
    end
    checks++;
  endtask

  task automatic test_busy_idle;
    int a0, n;
    logic [4:0] dval;
    busy_force = 1'b1;
    set_client(CL_CB, 1'b0, CB_BASE, 3'd1, '0);
    a0 = addr_log.size();
    req = 5'b01000;
    repeat (6) @(negedge clk);
    if (gnt !== 5'b0) begin errors++; $display("FAIL busy_idle_gnt: got %b want 0", gnt); end
    checks++;
    if (addr_log.size() != a0) begin
      errors++; $display("FAIL busy_idle_strobe: got %0d strobes want 0", addr_log.size() - a0);
    end
    checks++;
    busy_force = 1'b0;
    wait_done(40, n, dval);
    req = 5'b0;
    repeat (3) @(negedge clk);
    if (dval !== 5'b01000) begin errors++; $display("FAIL busy_idle_done: got %b want 01000", dval); end
    checks++;
  endtask

  task automatic test_reset_mid_burst;
    int d0, ns, n;
    logic [4:0] dval;
    logic [4:0] g;
    rd_off = rd_idx;
    rd_vals[0] = 32'h7777_0001;
    rd_vals[1] = 32'h7777_0002;
    rd_vals[2] = 32'h7777_0003;
    set_client(CL_HTREE, 1'b0, HTREE_BASE, 3'd3, '0);
    set_client(CL_HIST, 1'b0, HIST_BASE, 3'd1, '0);
    set_client(CL_TRANS, 1'b0, 32'h3300_4000, 3'd1, '0);
    d0 = done_cnt;
    ns = 0;
    req = 5'b00100;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 2) req = 5'b10101;
      if (r_en) ns++;
      if (ns == 2) break;
    end
    @(negedge clk);
    @(negedge clk);
    if (ns != 2 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_setup: strobes %0d busy %b want 2 and 0", ns, busy_o);
    end
    checks++;
    rst = 1'b1;
    #1;
    if (gnt !== 5'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0", gnt); end
    checks++;
    if (done !== 5'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++;
    if (rdata !== 128'b0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    checks++;
    if ({wr_en, r_en, select} !== 6'b0) begin
      errors++; $display("FAIL rst_strobes: got %b want 0", {wr_en, r_en, select});
    end
    checks++;
    if (addr !== 32'b0) begin errors++; $display("FAIL rst_addr: got %h want 0", addr); end
    checks++;
    if (data_i !== 32'b0) begin errors++; $display("FAIL rst_data_i: got %h want 0", data_i); end
    checks++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    g = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != 5'b0) begin g = gnt; break; end
    end
    if (g !== 5'b00001) begin errors++; $display("FAIL rst_next_grant: got %b want 00001", g); end
    checks++;
    if (done_cnt - d0 != 0) begin
      errors++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - d0);
    end
    checks++;
    req = 5'b0;
    wait_done(20, n, dval);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rd_vals[i] = '0;
    test_reset();
    test_round_robin();
    test_single_read();
    test_write_burst();
    test_len_edges();
    test_slow_bus();
    test_busy_idle();
    test_reset_mid_burst();
    if (sel_bad != 0) begin errors++; $display("FAIL select_rule: got %0d bad cycles want 0", sel_bad); end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
